// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared encodings for the APB bridge master and its address decoder
package apb_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    ACCESS = ST_ACCESS,
    RESP   = ST_RESP
  } state_t;

  // One-hot slave selects on the shared peripheral bus
  localparam logic [1:0] PSEL_NONE = 2'b00;
  localparam logic [1:0] PSEL_GPIO = 2'b01;
  localparam logic [1:0] PSEL_UART = 2'b10;

  // Top address nibble that maps to each slave
  localparam logic [3:0] SLV_GPIO = 4'h0;
  localparam logic [3:0] SLV_UART = 4'h1;

endpackage

// File: rtl/apb_bridge_master_if.sv
// rtl/apb_bridge_master_if.sv - request/response and APB bus signals of the bridge
interface apb_bridge_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [1:0]        psel;
  logic              pen;
  logic              pwr;
  logic [ADDR_W-1:0] pAdd;
  logic [DATA_W-1:0] pwData;
  logic              pready;
  logic [DATA_W-1:0] prdata;

  // Bridge side: consumes requests, produces responses, drives the APB bus
  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output psel, pen, pwr, pAdd, pwData,
    input  pready, prdata
  );

  // Environment side: request source, response sink and APB slaves
  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  psel, pen, pwr, pAdd, pwData,
    output pready, prdata
  );

endinterface

// File: rtl/apb_addr_decode.sv
// rtl/apb_addr_decode.sv - maps the top address nibble to a slave select or a decode error
module apb_addr_decode
  import apb_pkg::*;
(
  input  logic [3:0] slv,
  output logic [1:0] psel,
  output logic       dec_err
);

  // Unknown nibbles select nothing and flag an error
  always_comb begin
    psel    = PSEL_NONE;
    dec_err = 1'b0;
    case (slv)
      SLV_GPIO: psel = PSEL_GPIO;
      SLV_UART: psel = PSEL_UART;
      default:  dec_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/apb_bridge_master.sv
// rtl/apb_bridge_master.sv - single-transfer APB master with decode, wait states and timeout
module apb_bridge_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  apb_bridge_master_if.master bus
);

  // Wide enough to hold TIMEOUT-1 even when TIMEOUT is 1
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state_q, state_nx;
  logic [1:0]        psel_q, psel_nx;
  logic              pen_q, pen_nx;
  logic              pwr_q, pwr_nx;
  logic [ADDR_W-1:0] padd_q, padd_nx;
  logic [DATA_W-1:0] pwdata_q, pwdata_nx;
  logic [DATA_W-1:0] rdata_q, rdata_nx;
  logic              err_q, err_nx;
  logic [CNT_W-1:0]  cnt_q, cnt_nx;

  logic [1:0]        dec_psel;
  logic              dec_err;

  apb_addr_decode u_dec (
    .slv     (bus.req_addr[ADDR_W-1 -: 4]),
    .psel    (dec_psel),
    .dec_err (dec_err)
  );

  // Next-state and next-output logic; registers hold unless a state says otherwise
  always_comb begin
    state_nx  = state_q;
    psel_nx   = psel_q;
    pen_nx    = pen_q;
    pwr_nx    = pwr_q;
    padd_nx   = padd_q;
    pwdata_nx = pwdata_q;
    rdata_nx  = rdata_q;
    err_nx    = err_q;
    cnt_nx    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (dec_err) begin
            rdata_nx = '0;
            err_nx   = 1'b1;
            state_nx = RESP;
          end else begin
            psel_nx   = dec_psel;
            pwr_nx    = bus.req_write;
            padd_nx   = bus.req_addr;
            pwdata_nx = bus.req_wdata;
            pen_nx    = 1'b0;
            state_nx  = SETUP;
          end
        end
      end
      SETUP: begin
        pen_nx   = 1'b1;
        cnt_nx   = '0;
        state_nx = ACCESS;
      end
      ACCESS: begin
        if (bus.pready) begin
          rdata_nx = pwr_q ? '0 : bus.prdata;
          err_nx   = 1'b0;
          psel_nx  = PSEL_NONE;
          pen_nx   = 1'b0;
          state_nx = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_nx = '0;
          err_nx   = 1'b1;
          psel_nx  = PSEL_NONE;
          pen_nx   = 1'b0;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and bus registers; reset drops any transfer in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      psel_q   <= PSEL_NONE;
      pen_q    <= 1'b0;
      pwr_q    <= 1'b0;
      padd_q   <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_nx;
      psel_q   <= psel_nx;
      pen_q    <= pen_nx;
      pwr_q    <= pwr_nx;
      padd_q   <= padd_nx;
      pwdata_q <= pwdata_nx;
      rdata_q  <= rdata_nx;
      err_q    <= err_nx;
      cnt_q    <= cnt_nx;
    end
  end

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.psel      = psel_q;
  assign bus.pen       = pen_q;
  assign bus.pwr       = pwr_q;
  assign bus.pAdd      = padd_q;
  assign bus.pwData    = pwdata_q;

endmodule

// File: tb/tb_apb_bridge_master.sv
// tb/tb_apb_bridge_master.sv - scoreboard bench for the APB bridge master
module tb_apb_bridge_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_bridge_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_bridge_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          c0;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rsp_cnt  = 0;
  int   last_rsp_cyc = 0;
  int   hs_c     = 0;
  int   acc_cycles = 0;
  int   acc_n    = 0;
  int   ws       = 0;
  bit   tie_ready = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Slave model: pready after ws wait states in ACCESS, or tied high
  always @(negedge clk) begin
    if (bus.pen) begin
      bus.pready = tie_ready || (acc_n >= ws);
      acc_n++;
      acc_cycles++;
    end else begin
      acc_n = 0;
      bus.pready = tie_ready;
    end
  end

  // Response monitor: pop the scoreboard on every rsp_valid
  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      exp_t e;
      rsp_cnt++;
      last_rsp_cyc = cyc;
      chk("rsp_req_ready", bus.req_ready, 0);
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_err", bus.rsp_err, e.err);
        chk("rsp_latency", cyc - e.c0, e.lat);
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd_exp, input logic err_exp, input int lat_exp,
                       input bit push, input bit keep);
    exp_t e;
    int n = 0;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk("handshake_timeout", 0, 1);
      bus.req_valid = 1'b0;
      return;
    end
    e.rdata = rd_exp;
    e.err   = err_exp;
    e.lat   = lat_exp;
    e.c0    = cyc;
    hs_c    = cyc;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int start, input int budget);
    int n = 0;
    while (rsp_cnt == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (rsp_cnt == start) chk("rsp_wait_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs1;
    int start;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.prdata    = 32'h1234_5678;
    bus.pready    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_psel", bus.psel, 0);
    chk("rst_pen", bus.pen, 0);
    chk("rst_pwr", bus.pwr, 0);
    chk("rst_paddr", bus.pAdd, 0);
    chk("rst_pwdata", bus.pwData, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", bus.req_ready, 1);

    // Uart write with pready tied high (also outside ACCESS)
    tie_ready = 1'b1;
    issue(1'b1, 32'h1000_000F, 32'h0000_00A5, 32'h0, 1'b0, 3, 1'b1, 1'b0);
    @(negedge clk);
    chk("wr_setup_psel", bus.psel, 2'b10);
    chk("wr_setup_pen", bus.pen, 0);
    chk("wr_setup_pwr", bus.pwr, 1);
    chk("wr_setup_paddr", bus.pAdd, 32'h1000_000F);
    chk("wr_setup_pwdata", bus.pwData, 32'hA5);
    chk("wr_setup_ready", bus.req_ready, 0);
    @(negedge clk);
    chk("wr_access_psel", bus.psel, 2'b10);
    chk("wr_access_pen", bus.pen, 1);
    chk("wr_access_ready", bus.req_ready, 0);
    @(negedge clk);
    chk("wr_resp_psel", bus.psel, 0);
    chk("wr_resp_pen", bus.pen, 0);
    chk("wr_resp_paddr_hold", bus.pAdd, 32'h1000_000F);
    @(negedge clk);
    chk("wr_idle_ready", bus.req_ready, 1);

    // GPIO read with 2 wait states
    tie_ready = 1'b0;
    ws = 2;
    bus.prdata = 32'hDEAD_BEEF;
    start = rsp_cnt;
    issue(1'b0, 32'h0000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 5, 1'b1, 1'b0);
    wait_rsp(start, 20);
    @(negedge clk);

    // Decode error: no bus activity
    start = rsp_cnt;
    issue(1'b1, 32'h2000_0000, 32'h55, 32'h0, 1'b1, 1, 1'b1, 1'b0);
    chk("dec_psel", bus.psel, 0);
    chk("dec_pen", bus.pen, 0);
    chk("dec_paddr_hold", bus.pAdd, 32'h0000_0004);
    wait_rsp(start, 10);
    @(negedge clk);

    // Timeout: Uart read with pready held low
    ws = 1000;
    acc_cycles = 0;
    start = rsp_cnt;
    issue(1'b0, 32'h1000_0020, 32'h0, 32'h0, 1'b1, 18, 1'b1, 1'b0);
    wait_rsp(start, 40);
    chk("to_access_cycles", acc_cycles, 16);
    chk("to_psel", bus.psel, 0);
    chk("to_pen", bus.pen, 0);
    @(negedge clk);

    // Mixed random transfers
    for (int i = 0; i < 8; i++) begin
      logic        wr;
      logic [3:0]  nib;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        e_err;
      int          e_lat;
      wr  = 1'($urandom_range(0, 1));
      nib = 4'($urandom_range(0, 3));
      addr = {nib, 28'($urandom)};
      wd  = $urandom;
      ws  = $urandom_range(0, 3);
      bus.prdata = $urandom;
      e_err = (nib > 4'h1);
      e_lat = e_err ? 1 : 3 + ws;
      start = rsp_cnt;
      issue(wr, addr, wd, (e_err || wr) ? 32'h0 : bus.prdata, e_err, e_lat, 1'b1, 1'b0);
      wait_rsp(start, 20);
      @(negedge clk);
    end

    // Back-to-back writes with req_valid held
    tie_ready = 1'b1;
    issue(1'b1, 32'h0000_0010, 32'h11, 32'h0, 1'b0, 3, 1'b1, 1'b1);
    hs1 = hs_c;
    issue(1'b1, 32'h1000_0014, 32'h22, 32'h0, 1'b0, 3, 1'b1, 1'b0);
    chk("b2b_after_rsp", hs_c, last_rsp_cyc + 1);
    chk("b2b_spacing", hs_c - hs1, 4);
    start = rsp_cnt;
    wait_rsp(start, 10);
    @(negedge clk);

    // Reset during ACCESS drops the transfer
    tie_ready = 1'b0;
    ws = 1000;
    issue(1'b0, 32'h1000_0000, 32'h0, 32'h0, 1'b0, 0, 1'b0, 1'b0);
    begin
      int n = 0;
      while (!bus.pen && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("rstmid_reach_access", bus.pen, 1);
    end
    start = rsp_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_psel", bus.psel, 0);
    chk("rstmid_pen", bus.pen, 0);
    chk("rstmid_rsp_valid", bus.rsp_valid, 0);
    chk("rstmid_ready_in_rst", bus.req_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_ready_after", bus.req_ready, 1);
    repeat (20) @(negedge clk);
    chk("rstmid_no_rsp", rsp_cnt, start);

    // Bridge usable after reset
    tie_ready = 1'b1;
    start = rsp_cnt;
    issue(1'b1, 32'h0000_0008, 32'h77, 32'h0, 1'b0, 3, 1'b1, 1'b0);
    wait_rsp(start, 10);
    repeat (2) @(negedge clk);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
